channel_pixel_writer: RTL and testbench
=======================================

Name: channel_pixel_writer

Overview:
Upstream stage that fills the shared image memory consumed by the VGA image display path. Accepts a ready/valid stream of 8-bit pixels for one 256x256 colour channel and packs 8 pixels per 64-bit word, first pixel in bits [63:56]. Writes each word to memory port A at the channel's region base plus word index. One frame is one full channel, 8192 words.

Parameters:
IMG_W, 256, pixels per line
IMG_H, 256, lines per frame
ADDR_W, 16, memory address width
RED_BASE, 24576, word address of red region
GREEN_BASE, 32768, word address of green region
BLUE_BASE, 40960, word address of blue region

Ports:
clk_FPGA  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a frame
channel  in  2  00 red, 01 green, 10 blue, 11 invalid
pix_in  in  8  pixel data
pix_valid  in  1  pix_in valid
pix_ready  out  1  writer accepts pixel this cycle
addressA  out  ADDR_W  memory write address
dataA  out  64  packed pixel word
wrenA  out  1  memory write enable, one cycle per word
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last word written
checksum  out  24  pixel sum (see Optional Feature)

Behaviour:
- Single clock domain: clk_FPGA. rst is synchronous and active-high. All outputs are registered.
- Reset values: pix_ready=0, wrenA=0, addressA=0, dataA=0, busy=0, done=0, checksum=0. State goes to IDLE.
- Words per frame: WORDS = IMG_W*IMG_H/8 = 8192. word_idx is 13 bits; byte_cnt is 3 bits.
- IDLE:
  - start=1 and channel!=11: latch channel, base, word_idx=0, byte_cnt=0; go to FILL next cycle.
  - start with channel=11 is ignored; state stays IDLE.
- FILL: pix_ready=1, busy=1.
  - On pix_valid&pix_ready: shift register takes pixel; the 8th accepted pixel lands in [7:0], the first in [63:56].
  - byte_cnt increments on each handshake. When byte_cnt==7 and a handshake occurs, go to WRITE.
- WRITE: exactly one cycle.
  - wrenA=1, addressA=base+word_idx, dataA=packed word.
  - pix_ready=0.
  - If word_idx==WORDS-1, go to DONE; otherwise word_idx+1, then FILL.
- DONE: done=1 for one cycle; busy falls in the same cycle; return to IDLE.
- Latency: wrenA asserts the cycle after the 8th handshake. Peak rate is 8 pixels per 9 cycles.
- pix_valid while not in FILL has no effect; the producer holds the data.
- start while busy is ignored.
- Address arithmetic is ADDR_W bits. Bases are aligned so base+8191 never overflows: max 40960+8191=49151.
- rst mid-frame: next edge returns to IDLE with wrenA=0; the partial word is discarded, no write is issued.
- addressA and dataA hold their last values outside WRITE.

Optional Feature:
CHANNEL_WRITER_CHECKSUM_EN
- Defined: 24-bit accumulator cleared on accepted start, adds each accepted pixel (max sum 16711680, no overflow). checksum is updated when done pulses and held until the next start.
- Undefined: checksum is tied to 0 and no accumulator is built.

Decomposition:
- Package image_pkg:
  - channel_t enum (RED=0, GREEN=1, BLUE=2).
  - Region base constants and WORDS_PER_CHANNEL=8192.
  - writer_state_t enum (IDLE, FILL, WRITE, DONE).
  - Shared with the display reader.
- Sub-module pixel_pack8: an 8x8-bit shift register with load-enable, clear, and full flag at count 8.

Test Plan:
1. Reset → all outputs 0; start with channel=01 → busy=1, pix_ready=1 the next cycle.
2. channel=00, feed pixels 0x01..0x08 back-to-back → one wrenA, addressA=24576, dataA=0x0102030405060708; pix_ready=0 during WRITE.
3. channel=10, full frame with pix_in=index[7:0] and random valid gaps → 8192 writes at addresses 40960..49151 in order; done pulses once, one cycle after the last write; no write during a gap.
4. start with channel=11 → state stays IDLE, pix_ready=0, no wrenA; a start while busy does not restart the word count.
5. rst asserted after 5 pixels of word 3 → next cycle IDLE, wrenA never asserts for that word; a new start writes from word 0.
6. With CHANNEL_WRITER_CHECKSUM_EN, a frame of all 0xFF → checksum=0xFF0000 at done; without the macro → checksum=0.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the image memory fill and display paths.
//
// Contents:
//   channel_t          colour channel select (RED, GREEN, BLUE; 2'b11 is invalid)
//   writer_state_t     channel_pixel_writer FSM states
//   *_REGION_BASE      word address of each channel's region in the image memory
//   WORDS_PER_CHANNEL  64-bit words holding one 256x256 channel
package image_pkg;

    localparam int IMG_W_DEFAULT     = 256;
    localparam int IMG_H_DEFAULT     = 256;
    localparam int MEM_ADDR_W        = 16;
    localparam int PIX_PER_WORD      = 8;
    localparam int WORDS_PER_CHANNEL = IMG_W_DEFAULT * IMG_H_DEFAULT / PIX_PER_WORD;

    localparam int RED_REGION_BASE   = 24576;
    localparam int GREEN_REGION_BASE = 32768;
    localparam int BLUE_REGION_BASE  = 40960;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } channel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

endpackage

// File: rtl/channel_pixel_writer_if.sv
// Pixel stream in and memory port A out of channel_pixel_writer.
//
// Signals:
//   pix_in/pix_valid/pix_ready  8-bit ready/valid pixel stream
//   addressA/dataA/wrenA        word write port into the image memory
// Modports:
//   master  producer / memory side (drives pixels, observes writes)
//   slave   the writer
interface channel_pixel_writer_if
    import image_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) ();

    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] addressA;
    logic [63:0]       dataA;
    logic              wrenA;

    modport master (
        output pix_in, pix_valid,
        input  pix_ready, addressA, dataA, wrenA
    );

    modport slave (
        input  pix_in, pix_valid,
        output pix_ready, addressA, dataA, wrenA
    );

endinterface

// File: rtl/pixel_pack8.sv
// Packs eight 8-bit pixels into one 64-bit word, first pixel in [63:56].
//
// Ports:
//   clk_FPGA   clock
//   rst        synchronous active-high reset
//   clr        drop the partial word and restart the count
//   load       shift din in (ignored once full)
//   din        pixel byte
//   word_next  word as it will be after shifting din in this cycle
//   cnt        pixels held, modulo 8
//   full       eight pixels held
module pixel_pack8
    import image_pkg::*;
(
    input  logic        clk_FPGA,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  din,
    output logic [63:0] word_next,
    output logic [2:0]  cnt,
    output logic        full
);

    logic [63:0] word_q;
    logic [3:0]  cnt_q;

    // The writer needs the word including the 8th pixel on the same edge
    // that accepts it, so the shifted value is exposed combinationally.
    assign word_next = {word_q[55:0], din};
    assign cnt       = cnt_q[2:0];
    assign full      = cnt_q[3];

    always_ff @(posedge clk_FPGA) begin
        if (rst || clr) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (load && !full) begin
            word_q <= word_next;
            cnt_q  <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/channel_pixel_writer.sv
// Fills one colour channel of the shared image memory from a pixel stream.
// Eight pixels are packed per 64-bit word and written to port A at
// region base + word index; a frame is IMG_W*IMG_H/8 words.
//
// Ports:
//   clk_FPGA  clock
//   rst       synchronous active-high reset
//   start     one-cycle frame request (accepted only in IDLE, channel != 2'b11)
//   channel   00 red, 01 green, 10 blue, 11 invalid
//   bus       pixel stream in, memory port A out (slave modport)
//   busy      frame in progress (FILL/WRITE)
//   done      one-cycle pulse after the last word is written
//   checksum  pixel sum of the last frame, 0 when the feature is not built
//
// Build option: CHANNEL_WRITER_CHECKSUM_EN builds the pixel-sum accumulator.
//
// state | meaning
// IDLE  | waiting for a valid start
// FILL  | accepting pixels into the packer
// WRITE | one-cycle write of the packed word
// DONE  | done pulse, then back to IDLE
module channel_pixel_writer
    import image_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEFAULT,
    parameter int IMG_H      = IMG_H_DEFAULT,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int RED_BASE   = RED_REGION_BASE,
    parameter int GREEN_BASE = GREEN_REGION_BASE,
    parameter int BLUE_BASE  = BLUE_REGION_BASE
) (
    input  logic                   clk_FPGA,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             channel,
    channel_pixel_writer_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic [23:0]            checksum
);

    localparam int WORDS  = IMG_W * IMG_H / PIX_PER_WORD;
    localparam int WIDX_W = $clog2(WORDS);

    writer_state_t     state, next_state;
    logic [ADDR_W-1:0] base_q, base_sel;
    logic [WIDX_W-1:0] word_idx;
    logic              pix_ready_q;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       data_q;

    logic              start_ok;
    logic              pack_load;
    logic              pack_clr;
    logic [63:0]       pack_next;
    logic [2:0]        byte_cnt;
    logic              pack_full;
    logic              last_word;

    assign bus.pix_ready = pix_ready_q;
    assign bus.wrenA     = wren_q;
    assign bus.addressA  = addr_q;
    assign bus.dataA     = data_q;

    assign last_word = (word_idx == WIDX_W'(WORDS - 1));

    always_comb begin
        base_sel = ADDR_W'(RED_BASE);
        case (channel)
            GREEN:   base_sel = ADDR_W'(GREEN_BASE);
            BLUE:    base_sel = ADDR_W'(BLUE_BASE);
            default: base_sel = ADDR_W'(RED_BASE);
        endcase
    end

    pixel_pack8 u_pack (
        .clk_FPGA  (clk_FPGA),
        .rst       (rst),
        .clr       (pack_clr),
        .load      (pack_load),
        .din       (bus.pix_in),
        .word_next (pack_next),
        .cnt       (byte_cnt),
        .full      (pack_full)
    );

    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        pack_load  = 1'b0;
        pack_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start && channel != 2'b11) begin
                    start_ok   = 1'b1;
                    pack_clr   = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                if (bus.pix_valid && pix_ready_q) begin
                    pack_load = 1'b1;
                    if (byte_cnt == 3'd7) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                pack_clr   = pack_full;
                next_state = last_word ? DONE : FILL;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they describe rather than lagging it by a cycle.
    always_ff @(posedge clk_FPGA) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            word_idx    <= '0;
            pix_ready_q <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            pix_ready_q <= (next_state == FILL);
            wren_q      <= (next_state == WRITE);
            busy        <= (next_state == FILL) || (next_state == WRITE);
            done        <= (next_state == DONE);
            if (start_ok) begin
                base_q   <= base_sel;
                word_idx <= '0;
            end else if (state == WRITE && next_state == FILL) begin
                word_idx <= word_idx + 1'b1;
            end
            if (next_state == WRITE) begin
                addr_q <= base_q + ADDR_W'(word_idx);
                data_q <= pack_next;
            end
        end
    end

`ifdef CHANNEL_WRITER_CHECKSUM_EN
    logic [23:0] acc;

    always_ff @(posedge clk_FPGA) begin
        if (rst) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            if (start_ok) begin
                acc <= '0;
            end else if (pack_load) begin
                acc <= acc + {16'd0, bus.pix_in};
            end
            // acc already holds the last pixel by the time WRITE hands over
            if (next_state == DONE) begin
                checksum <= acc;
            end
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_channel_pixel_writer.sv
module tb_channel_pixel_writer;
    import image_pkg::*;

    logic        clk_FPGA = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  channel;
    logic        busy;
    logic        done;
    logic [23:0] checksum;

    always #5 clk_FPGA = ~clk_FPGA;

    channel_pixel_writer_if #(.ADDR_W(16)) bus ();

    channel_pixel_writer dut (
        .clk_FPGA (clk_FPGA),
        .rst      (rst),
        .start    (start),
        .channel  (channel),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // write scoreboard: expected data queued by stimulus, address from base + count
    logic [63:0] exp_q[$];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          wc_base  = 0;
    logic [15:0] addr_base = '0;

    always @(negedge clk_FPGA) begin
        if (!rst && bus.wrenA) begin
            chk("wr_addr", 64'(bus.addressA), 64'(addr_base + 16'(wr_cnt - wc_base)));
            if (exp_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
            else                   chk("wr_data", bus.dataA, exp_q.pop_front());
            chk("ready_in_write", 64'(bus.pix_ready), 64'd0);
            wr_cnt++;
        end
        if (!rst && done) done_cnt++;
    end

    function automatic logic [63:0] pack_seq(input logic [7:0] b);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[63-8*k -: 8] = b + 8'(k);
        return r;
    endfunction

    task automatic do_start(input logic [1:0] ch);
        channel = ch;
        start   = 1'b1;
        @(negedge clk_FPGA);
        start   = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] p, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 15) == 0) begin
            bus.pix_valid = 1'b0;
            @(negedge clk_FPGA);
        end
        bus.pix_in    = p;
        bus.pix_valid = 1'b1;
        n = 0;
        while (!bus.pix_ready && n < 50) begin
            @(negedge clk_FPGA);
            n++;
        end
        if (!bus.pix_ready) chk("ready_timeout", 64'd0, 64'd1);
        else @(negedge clk_FPGA);
        bus.pix_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b, input bit gaps);
        exp_q.push_back(pack_seq(b));
        for (int k = 0; k < 8; k++) send_pixel(b + 8'(k), gaps);
        chk("wren_latency", 64'(bus.wrenA), 64'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk_FPGA);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk_FPGA);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int          wc;
    int          d0;
    logic [23:0] exp_sum;

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        channel       = 2'b00;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        repeat (3) @(negedge clk_FPGA);

        // reset values
        chk("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
        chk("rst_wrenA",     64'(bus.wrenA),     64'd0);
        chk("rst_addressA",  64'(bus.addressA),  64'd0);
        chk("rst_dataA",     bus.dataA,          64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_done",      64'(done),          64'd0);
        chk("rst_checksum",  64'(checksum),      64'd0);
        rst = 1'b0;
        @(negedge clk_FPGA);

        // start green: busy and ready the next cycle
        do_start(2'b01);
        chk("start_busy",  64'(busy),          64'd1);
        chk("start_ready", 64'(bus.pix_ready), 64'd1);
        pulse_reset();
        chk("abort_busy",  64'(busy),          64'd0);

        // red, pixels 01..08 back-to-back
        addr_base = 16'd24576;
        wc_base   = wr_cnt;
        exp_q.push_back(64'h0102030405060708);
        do_start(2'b00);
        for (int k = 1; k <= 8; k++) send_pixel(8'(k), 1'b0);
        chk("red_wren", 64'(bus.wrenA), 64'd1);
        @(negedge clk_FPGA);
        chk("red_wr_cnt", 64'(wr_cnt - wc_base), 64'd1);
        chk("red_wren_drop", 64'(bus.wrenA), 64'd0);

        // start while busy must not restart the word index (next write at base+1)
        do_start(2'b10);
        send_word(8'h09, 1'b0);
        @(negedge clk_FPGA);
        chk("busy_start_wr_cnt", 64'(wr_cnt - wc_base), 64'd2);
        pulse_reset();

        // invalid channel start is ignored
        wc = wr_cnt;
        do_start(2'b11);
        for (int k = 0; k < 3; k++) begin
            chk("inv_busy",  64'(busy),          64'd0);
            chk("inv_ready", 64'(bus.pix_ready), 64'd0);
            chk("inv_wrenA", 64'(bus.wrenA),     64'd0);
            @(negedge clk_FPGA);
        end
        chk("inv_wr_cnt", 64'(wr_cnt - wc), 64'd0);

        // reset after 5 pixels of word 3 discards the word
        addr_base = 16'd32768;
        wc_base   = wr_cnt;
        do_start(2'b01);
        send_word(8'h20, 1'b1);
        send_word(8'h28, 1'b1);
        send_word(8'h30, 1'b1);
        for (int k = 0; k < 5; k++) send_pixel(8'h38 + 8'(k), 1'b0);
        wc = wr_cnt;
        chk("pre_rst_wr_cnt", 64'(wc - wc_base), 64'd3);
        rst = 1'b1;
        @(negedge clk_FPGA);
        chk("mid_rst_busy",  64'(busy),          64'd0);
        chk("mid_rst_ready", 64'(bus.pix_ready), 64'd0);
        chk("mid_rst_wrenA", 64'(bus.wrenA),     64'd0);
        chk("mid_rst_dataA", bus.dataA,          64'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk_FPGA);
        chk("mid_rst_no_write", 64'(wr_cnt - wc), 64'd0);
        wc_base = wr_cnt;
        do_start(2'b01);
        send_word(8'h40, 1'b0);
        @(negedge clk_FPGA);
        chk("restart_wr_cnt", 64'(wr_cnt - wc_base), 64'd1);
        pulse_reset();

        // full blue frame, pix_in = index[7:0], sparse valid gaps
        addr_base = 16'd40960;
        wc_base   = wr_cnt;
        d0        = done_cnt;
`ifdef CHANNEL_WRITER_CHECKSUM_EN
        exp_sum = 24'h7F8000;
`else
        exp_sum = 24'h000000;
`endif
        do_start(2'b10);
        for (int w = 0; w < WORDS_PER_CHANNEL; w++) begin
            send_word(8'(w * 8), 1'b1);
            chk("frame_busy", 64'(busy), 64'd1);
        end
        chk("frame_last_addr", 64'(bus.addressA), 64'd49151);
        @(negedge clk_FPGA);
        chk("frame_done",     64'(done),     64'd1);
        chk("frame_busy_off", 64'(busy),     64'd0);
        chk("frame_wrenA",    64'(bus.wrenA), 64'd0);
        chk("frame_checksum", 64'(checksum), 64'(exp_sum));
        chk("frame_writes",   64'(wr_cnt - wc_base), 64'(WORDS_PER_CHANNEL));
        @(negedge clk_FPGA);
        chk("frame_done_pulse", 64'(done), 64'd0);
        chk("frame_idle_ready", 64'(bus.pix_ready), 64'd0);
        repeat (3) @(negedge clk_FPGA);
        chk("frame_done_count", 64'(done_cnt - d0), 64'd1);
        chk("frame_checksum_hold", 64'(checksum), 64'(exp_sum));
        chk("frame_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
